// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter family.
// Holds the FSM state enum, the rotate-priority pick function and the byte-select width helper.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_IDX_W   = $clog2(MAX_MASTERS);
    localparam int DEF_DAT_W   = 32;

    function automatic int sel_width(input int dat_w);
        return dat_w / 8;
    endfunction

    localparam int DEF_SEL_W = sel_width(DEF_DAT_W);

    // First requester scanning upward from last+1, wrapping at n.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input int unsigned            last,
        input int unsigned            n
    );
        logic [MAX_MASTERS-1:0] g;
        int unsigned            j;
        logic [MAX_IDX_W-1:0]   j_idx;
        g = '0;
        for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
            j = last + k;
            if (j >= n) j = j - n;
            j_idx = j[MAX_IDX_W-1:0];
            if (k <= n && g == '0 && req[j_idx]) g[j_idx] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotate-priority encoder: request vector plus last winner in,
// one-hot winner and its index out. Shared with other round-robin arbiters.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [MAX_MASTERS-1:0] w_req_ext;
    logic [MAX_MASTERS-1:0] w_pick;

    always_comb begin
        w_req_ext        = '0;
        w_req_ext[N-1:0] = req;
    end

    assign w_pick = rr_pick(w_req_ext, 32'(last), N);
    assign onehot = w_pick[N-1:0];
    assign any    = |w_pick;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master round-robin arbiter in front of one Wishbone B4 classic slave; grant is held for
// the owner's whole cyc. Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADR_W     = 32,
    parameter int DAT_W     = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_MASTERS-1:0]                  m_cyc,
    input  logic [N_MASTERS-1:0]                  m_stb,
    input  logic [N_MASTERS-1:0]                  m_we,
    input  logic [N_MASTERS*ADR_W-1:0]            m_adr,
    input  logic [N_MASTERS*DAT_W-1:0]            m_dat_w,
    input  logic [N_MASTERS*sel_width(DAT_W)-1:0] m_sel,
    output logic [DAT_W-1:0]                      m_dat_r,
    output logic [N_MASTERS-1:0]                  m_ack,
    output logic [N_MASTERS-1:0]                  m_err,
    output logic                                  s_cyc,
    output logic                                  s_stb,
    output logic                                  s_we,
    output logic [ADR_W-1:0]                      s_adr,
    output logic [DAT_W-1:0]                      s_dat_w,
    output logic [sel_width(DAT_W)-1:0]           s_sel,
    input  logic [DAT_W-1:0]                      s_dat_r,
    input  logic                                  s_ack,
    input  logic                                  s_err,
    output logic [N_MASTERS-1:0]                  grant
);

    localparam int SEL_W = sel_width(DAT_W);
    localparam int IDX_W = $clog2(N_MASTERS);

    arb_state_e           r_state, w_state_nxt;
    logic [N_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0]     r_last, w_last_nxt;
    logic [N_MASTERS-1:0] w_pick_oh;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_any;
    logic                 w_busy;
    logic                 w_own_cyc;
    logic                 w_stb_raw;
    logic                 w_timeout;

    wb_rr_pick #(.N(N_MASTERS), .IDX_W(IDX_W)) u_pick (
        .req    (m_cyc),
        .last   (r_last),
        .onehot (w_pick_oh),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    // r_last doubles as the owner index while BUSY, since it is set to the winner on grant.
    assign w_busy    = (r_state == BUSY);
    assign w_own_cyc = m_cyc[r_last];
    assign w_stb_raw = w_busy & w_own_cyc & m_stb[r_last];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_wd_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt <= '0;
        end else if (!w_busy || s_ack || s_err || w_timeout) begin
            r_wd_cnt <= '0;
        end else if (w_stb_raw) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th unanswered strobe cycle.
    assign w_timeout = w_stb_raw & ~s_ack & ~s_err & (r_wd_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IDX_W'(N_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick_oh;
                    w_last_nxt  = w_pick_idx;
                end
            end
            BUSY: begin
                if (!w_own_cyc || w_timeout) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
        endcase
    end

    assign s_cyc   = w_busy & w_own_cyc & ~w_timeout;
    assign s_stb   = w_stb_raw & ~w_timeout;
    assign s_we    = w_busy & m_we[r_last];
    assign s_adr   = w_busy ? m_adr[r_last*ADR_W +: ADR_W] : '0;
    assign s_dat_w = w_busy ? m_dat_w[r_last*DAT_W +: DAT_W] : '0;
    assign s_sel   = w_busy ? m_sel[r_last*SEL_W +: SEL_W] : '0;

    assign m_ack   = r_grant & {N_MASTERS{s_ack & s_cyc}};
    assign m_err   = r_grant & {N_MASTERS{(s_err & s_cyc) | w_timeout}};
    assign m_dat_r = s_dat_r;
    assign grant   = r_grant;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter (3 masters): random master transactors, a slave memory
// model and an owner/rotation reference model; watchdog section depends on WB_ARB_TIMEOUT_EN.
module tb_wb_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_cyc, m_stb, m_we, m_ack, m_err, grant;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   m_dat_r, s_dat_w, s_dat_r;
    logic            s_cyc, s_stb, s_we, s_ack, s_err;
    logic [AW-1:0]   s_adr;
    logic [SW-1:0]   s_sel;

    logic          tb_cyc [N];
    logic          tb_stb [N];
    logic          tb_we  [N];
    logic [AW-1:0] tb_adr [N];
    logic [DW-1:0] tb_dat [N];
    logic [SW-1:0] tb_sel [N];

    always_comb begin
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_sel = '0;
        for (int i = 0; i < N; i++) begin
            m_cyc[i]             = tb_cyc[i];
            m_stb[i]             = tb_stb[i];
            m_we[i]              = tb_we[i];
            m_adr[i*AW +: AW]    = tb_adr[i];
            m_dat_w[i*DW +: DW]  = tb_dat[i];
            m_sel[i*SW +: SW]    = tb_sel[i];
        end
    end

    wb_rr_arbiter #(.N_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .grant(grant)
    );

    function automatic logic [31:0] init_word(input int w);
        return (w == 64) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(w));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] sl);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (sl[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Slave: memory with random ack latency (bounded to a few cycles) unless hung.
    logic [31:0] smem [256];
    logic        rdy;
    int          wcnt;
    logic        hang = 1'b0;

    assign s_ack   = s_cyc & s_stb & rdy;
    assign s_err   = 1'b0;
    assign s_dat_r = smem[s_adr[9:2]];

    always @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < 256; w++) smem[w] <= init_word(w);
            rdy  <= 1'b0;
            wcnt <= 0;
        end else begin
            if (s_ack && s_we) smem[s_adr[9:2]] <= merge(smem[s_adr[9:2]], s_dat_w, s_sel);
            wcnt <= (s_cyc && s_stb && !s_ack) ? wcnt + 1 : 0;
            rdy  <= !hang && (($urandom_range(0, 3) != 0) || wcnt >= 2);
        end
    end

    logic [31:0] ref_mem [256];
    logic [32:0] exp_q [N][$];
    int          rv [$];
    int          rl [$];
    int          mown, mlast;
    logic        chk_en = 1'b1;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ref_init();
        for (int w = 0; w < 256; w++) ref_mem[w] = init_word(w);
    endtask

    function automatic int next_owner(input int last);
        for (int k = 1; k <= N; k++) begin
            if (tb_cyc[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Reference: idle bus goes to the first requester after the last owner; owner keeps it while cyc holds.
    task automatic model();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mown  <= -1;
                mlast <= N - 1;
            end else if (mown < 0) begin
                if (next_owner(mlast) >= 0) begin
                    mown  <= next_owner(mlast);
                    mlast <= next_owner(mlast);
                end
            end else if (!tb_cyc[mown]) begin
                mown <= -1;
            end
        end
    endtask

    task automatic monitor();
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rv.size() == 0 || rv[$] != int'(grant)) begin
                rv.push_back(int'(grant));
                rl.push_back(1);
            end else begin
                rl[$] = rl[$] + 1;
            end
            if (rst && chk_en) begin
                check("grant", grant, (mown < 0) ? 0 : (1 << mown));
                if (mown >= 0) begin
                    check("s_adr", s_adr, tb_adr[mown]);
                    check("s_cyc", s_cyc, tb_cyc[mown]);
                    check("s_stb", s_stb, tb_cyc[mown] & tb_stb[mown]);
                end else begin
                    check("s_cyc_idle", s_cyc, 0);
                end
                check("m_err", m_err, 0);
                for (int i = 0; i < N; i++) begin
                    if (m_ack[i]) begin
                        check("ack_owner", i, mown);
                        check("ack_pending", exp_q[i].size() > 0, 1);
                        if (exp_q[i].size() > 0) begin
                            e = exp_q[i].pop_front();
                            if (!e[32]) check("rd_data", m_dat_r, e[31:0]);
                        end
                    end
                end
            end
        end
    endtask

    // mode 0: random read/write in own region, 1: full-word writes, 2: reads of word fixw
    task automatic do_cycle(input int i, input int nb, input int mode, input int fixw);
        int          w, n;
        logic [31:0] d;
        logic [3:0]  sl;
        logic        we;
        tb_cyc[i] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            w  = (mode == 2) ? fixw : 128 + i*32 + int'($urandom_range(0, 31));
            we = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            d  = $urandom;
            sl = (mode == 0 && we) ? 4'($urandom_range(1, 15)) : 4'hF;
            if (we) begin
                ref_mem[w] = merge(ref_mem[w], d, sl);
                exp_q[i].push_back({1'b1, 32'h0});
            end else begin
                exp_q[i].push_back({1'b0, ref_mem[w]});
            end
            tb_adr[i] = 32'(w) << 2;
            tb_we[i]  = we;
            tb_dat[i] = d;
            tb_sel[i] = sl;
            tb_stb[i] = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!m_ack[i] && n < 400);
            if (!m_ack[i]) check("ack_wait", m_ack[i], 1);
            tick();
            tb_stb[i] = 1'b0;
        end
        tb_cyc[i] = 1'b0;
        tb_we[i]  = 1'b0;
        tick();
    endtask

    task automatic rnd_master(input int i);
        repeat (6) begin
            repeat ($urandom_range(0, 3)) tick();
            do_cycle(i, int'($urandom_range(1, 3)), 0, 0);
        end
    endtask

    task automatic check_seq(input string nm, input int ev [8], input int n);
        check({nm, "_len"}, rv.size() >= n, 1);
        for (int k = 0; k < n; k++) begin
            if (k < rv.size()) check(nm, rv[k], ev[k]);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            tb_cyc[i] = 1'b1; tb_stb[i] = 1'b1; tb_we[i] = 1'b1;
            tb_adr[i] = 32'h40; tb_dat[i] = 32'h0; tb_sel[i] = 4'hF;
        end
        ref_init();
        fork
            model();
            monitor();
        join_none

        // Reset holds everything quiet even with all masters requesting
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_s_cyc", s_cyc, 0);
        check("rst_s_stb", s_stb, 0);
        check("rst_s_adr", s_adr, 0);
        check("rst_m_ack", m_ack, 0);
        check("rst_m_err", m_err, 0);
        for (int i = 0; i < N; i++) begin
            tb_cyc[i] = 1'b0; tb_stb[i] = 1'b0; tb_we[i] = 1'b0;
        end
        tick();
        rst = 1'b1;
        tick();

        // Master 0 alone: one-cycle latency, read of 0x100
        fork
            do_cycle(0, 1, 2, 64);
            begin
                @(negedge clk);
                check("t1_grant_lat", grant, 0);
                @(negedge clk);
                check("t1_grant", grant, 3'b001);
                check("t1_s_adr", s_adr, 32'h100);
                n = 0;
                while (m_ack == 0 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("t1_m_ack", m_ack, 3'b001);
                check("t1_dat", m_dat_r, 32'hDEADBEEF);
            end
        join

        // Two masters hammering: alternate owners with one idle cycle in between (last owner was 0)
        rv.delete(); rl.delete();
        fork
            repeat (2) do_cycle(0, 2, 0, 0);
            repeat (2) do_cycle(1, 2, 0, 0);
        join
        check_seq("t2_seq", '{0, 2, 0, 1, 0, 2, 0, 1}, 8);
        for (int k = 2; k <= 6; k += 2) if (k < rl.size()) check("t2_idle_len", rl[k], 1);

        // Master 1 write burst; master 0 waits until it drops cyc
        rv.delete(); rl.delete();
        fork
            do_cycle(1, 4, 1, 0);
            begin
                n = 0;
                while (grant != 3'b010 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("t3_owner1", grant, 3'b010);
                tick();
                do_cycle(0, 1, 0, 0);
            end
        join
        check_seq("t3_seq", '{0, 2, 0, 1, 0, 0, 0, 0}, 4);
        if (rl.size() > 2) check("t3_idle_len", rl[2], 1);

        // Three requesters with last=1: 2, 0, 1
        do_cycle(1, 1, 0, 0);
        rv.delete(); rl.delete();
        fork
            do_cycle(0, 1, 0, 0);
            do_cycle(1, 1, 0, 0);
            do_cycle(2, 1, 0, 0);
        join
        check_seq("t4_seq", '{0, 4, 0, 1, 0, 2, 0, 0}, 6);

        // Random traffic from all masters
        fork
            rnd_master(0);
            rnd_master(1);
            rnd_master(2);
        join
        for (int i = 0; i < N; i++) check("q_drained", exp_q[i].size(), 0);

        // Reset in the middle of a master-0 write
        hang = 1'b1;
        tb_cyc[0] = 1'b1; tb_stb[0] = 1'b1; tb_we[0] = 1'b1;
        tb_adr[0] = 32'h200; tb_dat[0] = 32'h12345678; tb_sel[0] = 4'hF;
        tick();
        tick();
        check("t5_owner0", grant, 3'b001);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_s_cyc", s_cyc, 0);
        check("t5_async_s_stb", s_stb, 0);
        check("t5_async_grant", grant, 0);
        tb_cyc[0] = 1'b0; tb_stb[0] = 1'b0; tb_we[0] = 1'b0;
        hang = 1'b0;
        @(posedge clk);
        tick();
        rst = 1'b1;
        ref_init();
        rv.delete(); rl.delete();
        fork
            do_cycle(0, 1, 0, 0);
            do_cycle(1, 1, 0, 0);
            do_cycle(2, 1, 0, 0);
        join
        check_seq("t5_seq", '{0, 1, 0, 2, 0, 4, 0, 0}, 6);

        // Slave that never answers
        hang = 1'b1;
        tb_cyc[0] = 1'b1; tb_stb[0] = 1'b1; tb_we[0] = 1'b0;
        tb_adr[0] = 32'h300; tb_sel[0] = 4'hF;
`ifdef WB_ARB_TIMEOUT_EN
        chk_en = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_stb) n++;
            if (m_err != 0) begin
                n++;
                break;
            end
        end
        check("t6_err_cycle", n, TO);
        check("t6_err_owner", m_err, 3'b001);
        check("t6_s_cyc_drop", s_cyc, 0);
        @(negedge clk);
        check("t6_idle_grant", grant, 0);
        check("t6_err_pulse", m_err, 0);
        tick();
        tb_cyc[0] = 1'b0; tb_stb[0] = 1'b0;
`else
        tick();
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (s_cyc) n++;
        end
        check("t6_hold", n, 100);
        tick();
        tb_cyc[0] = 1'b0; tb_stb[0] = 1'b0;
`endif
        hang = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
